bsg_upstream_io_tx: RTL and testbench

BSG_UPSTREAM_IO_TX -- requirements
Module: bsg_upstream_io_tx

---
 rtl/bsg_upstream_pkg.sv | 18 +
 rtl/bsg_credit_counter.sv | 38 +++
 rtl/bsg_upstream_io_tx.sv | 76 +++++++
 tb/tb_bsg_upstream_io_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_upstream_pkg.sv
// Shared types and default geometry for the upstream IO transmitter.
// BEATS is the number of IO beats needed to carry one core word.
package bsg_upstream_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    localparam int DEFAULT_CORE_WIDTH = 32;
    localparam int DEFAULT_IO_WIDTH   = 8;
    localparam int DEFAULT_CREDITS    = 16;

    function automatic int beats_of(input int core_width, input int io_width);
        return core_width / io_width;
    endfunction

endpackage

// File: rtl/bsg_credit_counter.sv
// Tracks receiver buffer credits: decrements on word accept, increments on returned token.
// A token that would push the count above CREDITS is discarded and flags a sticky overflow.
module bsg_credit_counter #(
    parameter int CREDITS = 16,
    localparam int CNT_W  = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= FULL;
            overflow <= 1'b0;
        end else begin
            case ({dec, inc})
                2'b10: begin
                    if (count != '0) count <= count - 1'b1;
                end
                2'b01: begin
                    if (count == FULL) overflow <= 1'b1;
                    else               count    <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/bsg_upstream_io_tx.sv
// Credit-gated serializer: one CORE_WIDTH word becomes BEATS IO beats, LSB beat first.
// A new word may be taken in IDLE or on the final beat of the current word, so streams have no bubbles.
module bsg_upstream_io_tx
    import bsg_upstream_pkg::*;
#(
    parameter int CORE_WIDTH = DEFAULT_CORE_WIDTH,
    parameter int IO_WIDTH   = DEFAULT_IO_WIDTH,
    parameter int CREDITS    = DEFAULT_CREDITS,
    localparam int CNT_W     = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_valid_i,
    input  logic [CORE_WIDTH-1:0] core_data_i,
    output logic                  core_ready_o,
    output logic                  io_valid_o,
    output logic [IO_WIDTH-1:0]   io_data_o,
    input  logic                  io_token_i,
    output logic [CNT_W-1:0]      credit_cnt_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int BEATS  = beats_of(CORE_WIDTH, IO_WIDTH);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    tx_state_e             state_r;
    logic [BEAT_W-1:0]     beat_r;
    logic [CORE_WIDTH-1:0] shift_r;
    logic                  credit_avail;
    logic                  accept;

    // Readiness depends only on registered state so the core never sees a valid->ready loop.
    assign core_ready_o = credit_avail &&
                          (state_r == ST_IDLE || (state_r == ST_SEND && beat_r == LAST_BEAT));
    assign accept       = core_valid_i && core_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            beat_r  <= '0;
            shift_r <= '0;
        end else if (accept) begin
            state_r <= ST_SEND;
            beat_r  <= '0;
            shift_r <= core_data_i;
        end else if (state_r == ST_SEND) begin
            if (beat_r == LAST_BEAT) begin
                state_r <= ST_IDLE;
                beat_r  <= '0;
                shift_r <= '0;
            end else begin
                beat_r  <= beat_r + 1'b1;
                shift_r <= shift_r >> IO_WIDTH;
            end
        end
    end

    assign io_valid_o = (state_r == ST_SEND);
    assign io_data_o  = io_valid_o ? shift_r[IO_WIDTH-1:0] : '0;
    assign busy_o     = io_valid_o;

    bsg_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .dec      (accept),
        .inc      (io_token_i),
        .count    (credit_cnt_o),
        .nonzero  (credit_avail),
        .overflow (err_o)
    );

endmodule

// File: tb/tb_bsg_upstream_io_tx.sv
// Directed bench for bsg_upstream_io_tx: single word, streaming, credit return,
// simultaneous accept/token, overflow and mid-word reset.
module tb_bsg_upstream_io_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid_i;
    logic [31:0] core_data_i;
    logic        core_ready_o;
    logic        io_valid_o;
    logic [7:0]  io_data_o;
    logic        io_token_i;
    logic [4:0]  credit_cnt_o;
    logic        busy_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bsg_upstream_io_tx #(
        .CORE_WIDTH (32),
        .IO_WIDTH   (8),
        .CREDITS    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_valid_i (core_valid_i),
        .core_data_i  (core_data_i),
        .core_ready_o (core_ready_o),
        .io_valid_o   (io_valid_o),
        .io_data_o    (io_data_o),
        .io_token_i   (io_token_i),
        .credit_cnt_o (credit_cnt_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    function automatic logic [31:0] stream_word(input int i);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4 * i);
        b1 = 8'(4 * i + 1);
        b2 = 8'(4 * i + 2);
        b3 = 8'(4 * i + 3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        core_valid_i = 1'b0;
        core_data_i  = '0;
        io_token_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers n words (base+k) until all are accepted or the cycle budget runs out.
    task automatic send_words(input int n, input logic [31:0] base);
        int acc = 0;
        int cyc = 0;
        logic a;
        core_valid_i = 1'b1;
        while (acc < n && cyc < 200) begin
            core_data_i = base + 32'(acc);
            a = core_ready_o;
            tick();
            if (a) acc++;
            cyc++;
        end
        core_valid_i = 1'b0;
        checks++;
        if (acc != n) begin
            failures++;
            $display("FAIL send_words: accepted=%0d expected=%0d", acc, n);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while (io_valid_o && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (io_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: io_valid=%b expected=0 after %0d cycles", io_valid_o, c);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (io_valid_o !== 1'b0 || io_data_o !== 8'h00 || busy_o !== 1'b0 ||
            credit_cnt_o !== 5'd16 || err_o !== 1'b0 || core_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h busy=%b cnt=%0d err=%b ready=%b expected 0 00 0 16 0 1",
                     io_valid_o, io_data_o, busy_o, credit_cnt_o, err_o, core_ready_o);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_reset();
        core_valid_i = 1'b1;
        core_data_i  = 32'hDDCCBBAA;
        checks++;
        if (core_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got=%b expected=1", core_ready_o);
        end
        tick();
        core_valid_i = 1'b0;
        checks++;
        if (credit_cnt_o !== 5'd15) begin
            failures++;
            $display("FAIL single_credit: got=%0d expected=15", credit_cnt_o);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (io_valid_o !== 1'b1 || busy_o !== 1'b1 || io_data_o !== exp_b[k]) begin
                failures++;
                $display("FAIL single_beat%0d: valid=%b busy=%b data=%h expected valid=1 busy=1 data=%h",
                         k, io_valid_o, busy_o, io_data_o, exp_b[k]);
            end
            tick();
        end
        checks++;
        if (io_valid_o !== 1'b0 || io_data_o !== 8'h00 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: valid=%b data=%h busy=%b expected 0 00 0",
                     io_valid_o, io_data_o, busy_o);
        end
    endtask

    task automatic test_streaming();
        int idx = 0;
        int beat_exp = 0;
        int cyc = 0;
        logic a;
        logic started = 1'b0;
        logic bubble = 1'b0;
        do_reset();
        while (beat_exp < 64 && cyc < 120) begin
            core_valid_i = (idx < 16);
            core_data_i  = stream_word(idx);
            a = core_valid_i && core_ready_o;
            tick();
            cyc++;
            if (a) begin
                idx++;
                if (idx == 16) begin
                    checks++;
                    if (core_ready_o !== 1'b0) begin
                        failures++;
                        $display("FAIL stream_ready_low: got=%b expected=0", core_ready_o);
                    end
                end
            end
            if (io_valid_o) begin
                started = 1'b1;
                checks++;
                if (io_data_o !== 8'(beat_exp)) begin
                    failures++;
                    $display("FAIL stream_beat%0d: got=%h expected=%h", beat_exp, io_data_o, 8'(beat_exp));
                end
                beat_exp++;
            end else if (started) begin
                bubble = 1'b1;
            end
        end
        core_valid_i = 1'b0;
        checks++;
        if (beat_exp != 64 || idx != 16 || bubble !== 1'b0 || credit_cnt_o !== 5'd0) begin
            failures++;
            $display("FAIL stream_totals: beats=%0d words=%0d bubble=%b cnt=%0d expected 64 16 0 0",
                     beat_exp, idx, bubble, credit_cnt_o);
        end
        tick();
        checks++;
        if (io_valid_o !== 1'b0 || core_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_end: valid=%b ready=%b expected 0 0", io_valid_o, core_ready_o);
        end
    endtask

    // Continues from the drained stream with zero credits.
    task automatic test_credit_return();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        io_token_i = 1'b1;
        tick();
        io_token_i = 1'b0;
        checks++;
        if (credit_cnt_o !== 5'd1 || core_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL credit_return: cnt=%0d ready=%b expected 1 1", credit_cnt_o, core_ready_o);
        end
        core_valid_i = 1'b1;
        core_data_i  = 32'h44332211;
        tick();
        core_valid_i = 1'b0;
        checks++;
        if (credit_cnt_o !== 5'd0 || core_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL credit_spent: cnt=%0d ready=%b expected 0 0", credit_cnt_o, core_ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (io_valid_o !== 1'b1 || io_data_o !== exp_b[k]) begin
                failures++;
                $display("FAIL credit_beat%0d: valid=%b data=%h expected 1 %h", k, io_valid_o, io_data_o, exp_b[k]);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send_words(11, 32'h1000_0000);
        wait_idle();
        checks++;
        if (credit_cnt_o !== 5'd5 || core_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL simul_pre: cnt=%0d ready=%b expected 5 1", credit_cnt_o, core_ready_o);
        end
        core_valid_i = 1'b1;
        core_data_i  = 32'h5A5A5A5A;
        io_token_i   = 1'b1;
        tick();
        core_valid_i = 1'b0;
        io_token_i   = 1'b0;
        checks++;
        if (credit_cnt_o !== 5'd5 || io_valid_o !== 1'b1 || io_data_o !== 8'h5A) begin
            failures++;
            $display("FAIL simul_post: cnt=%0d valid=%b data=%h expected 5 1 5a",
                     credit_cnt_o, io_valid_o, io_data_o);
        end
        wait_idle();
    endtask

    task automatic test_overflow();
        do_reset();
        io_token_i = 1'b1;
        tick();
        io_token_i = 1'b0;
        checks++;
        if (credit_cnt_o !== 5'd16 || err_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow: cnt=%0d err=%b expected 16 1", credit_cnt_o, err_o);
        end
        repeat (3) tick();
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: err=%b expected 1", err_o);
        end
        do_reset();
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: err=%b expected 0", err_o);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_b [4];
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        do_reset();
        core_valid_i = 1'b1;
        core_data_i  = 32'h88776655;
        tick();
        core_valid_i = 1'b0;
        checks++;
        if (io_data_o !== 8'h55) begin
            failures++;
            $display("FAIL midrst_beat0: got=%h expected=55", io_data_o);
        end
        tick();
        checks++;
        if (io_data_o !== 8'h66) begin
            failures++;
            $display("FAIL midrst_beat1: got=%h expected=66", io_data_o);
        end
        rst        = 1'b1;
        io_token_i = 1'b1;
        tick();
        checks++;
        if (io_valid_o !== 1'b0 || io_data_o !== 8'h00 || busy_o !== 1'b0 || credit_cnt_o !== 5'd16) begin
            failures++;
            $display("FAIL midrst_abort: valid=%b data=%h busy=%b cnt=%0d expected 0 00 0 16",
                     io_valid_o, io_data_o, busy_o, credit_cnt_o);
        end
        tick();
        rst        = 1'b0;
        io_token_i = 1'b0;
        checks++;
        if (credit_cnt_o !== 5'd16 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_token_ignored: cnt=%0d err=%b expected 16 0", credit_cnt_o, err_o);
        end
        core_valid_i = 1'b1;
        core_data_i  = 32'hA1B2C3D4;
        tick();
        core_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (io_valid_o !== 1'b1 || io_data_o !== exp_b[k]) begin
                failures++;
                $display("FAIL midrst_resend%0d: valid=%b data=%h expected 1 %h", k, io_valid_o, io_data_o, exp_b[k]);
            end
            tick();
        end
        checks++;
        if (io_valid_o !== 1'b0 || credit_cnt_o !== 5'd15) begin
            failures++;
            $display("FAIL midrst_end: valid=%b cnt=%0d expected 0 15", io_valid_o, credit_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_credit_return();
        test_simultaneous();
        test_overflow();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
